// File: rtl/axil_intr_responder.sv
// AXI4-Lite interrupt register block: GIE/IER/ISR/IAR/IPR over a 32-bit slave port,
// latching up to C_NUM_INTR peripheral events and driving one registered irq line.
module axil_intr_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_NUM_INTR         = 1,
  parameter bit C_INTR_SENSITIVITY = 1'b1,
  parameter bit C_IRQ_ACTIVE_STATE = 1'b1
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [C_NUM_INTR-1:0]           intr_src,
  output logic                            irq
);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int N = C_NUM_INTR;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = 32'd0;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

  function automatic logic [31:0] zext(input logic [N-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[N-1:0] = v;
    return r;
  endfunction

  logic [0:0]   wstate_q, wstate_d, rstate_q, rstate_d;
  logic         awready_q, awready_d, bvalid_q, bvalid_d;
  logic [1:0]   bresp_q, bresp_d, rresp_q, rresp_d;
  logic         arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         gie_q, gie_d, irq_q, irq_d;
  logic [N-1:0] ier_q, ier_d, isr_q, isr_d, src_q;
  logic [N-1:0] isr_set_s, isr_clr_s, evt_s;
  logic [31:0]  wmask_s, wbits_s, rd_mux_s;
  logic [1:0]   rd_resp_s;
  logic [2:0]   widx_s, ridx_s;
  logic         wr_hs_s, rd_hs_s, unused_s;

  assign wmask_s  = strb_mask(S_AXI_WSTRB);
  assign wbits_s  = S_AXI_WDATA & wmask_s;
  assign widx_s   = S_AXI_AWADDR[4:2];
  assign ridx_s   = S_AXI_ARADDR[4:2];
  // A single ready register serves both AW and W so they are always accepted together.
  assign wr_hs_s  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_hs_s  = arready_q & S_AXI_ARVALID;
  assign evt_s    = C_INTR_SENSITIVITY ? (intr_src & ~src_q) : intr_src;
  // Events are ORed in last so a same-cycle acknowledge can never hide a new event.
  assign isr_d    = (isr_q & ~isr_clr_s) | isr_set_s | evt_s;
  assign irq_d    = gie_q & (|(isr_q & ier_q));
  assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                      wbits_s, wmask_s};

  // Write channel FSM and register write decode
  always_comb begin
    wstate_d  = wstate_q;
    awready_d = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    gie_d     = gie_q;
    ier_d     = ier_q;
    isr_set_s = '0;
    isr_clr_s = '0;
    case (wstate_q)
      W_IDLE: begin
        if (wr_hs_s) begin
          wstate_d = W_RESP;
          bvalid_d = 1'b1;
          bresp_d  = (widx_s > 3'd4) ? RESP_SLVERR : RESP_OKAY;
          case (widx_s)
            3'd0:    gie_d     = (gie_q & ~wmask_s[0]) | wbits_s[0];
            3'd1:    ier_d     = (ier_q & ~wmask_s[N-1:0]) | wbits_s[N-1:0];
            3'd2:    isr_set_s = wbits_s[N-1:0];
            3'd3:    isr_clr_s = wbits_s[N-1:0];
            default: isr_set_s = '0;
          endcase
        end else begin
          awready_d = S_AXI_AWVALID & S_AXI_WVALID;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_d = W_IDLE;
          bvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        wstate_d = W_IDLE;
        bvalid_d = 1'b0;
        bresp_d  = RESP_OKAY;
      end
    endcase
  end

  // Read data mux, sampled at the AR handshake
  always_comb begin
    rd_mux_s  = 32'd0;
    rd_resp_s = RESP_OKAY;
    case (ridx_s)
      3'd0:    rd_mux_s = {31'd0, gie_q};
      3'd1:    rd_mux_s = zext(ier_q);
      3'd2:    rd_mux_s = zext(isr_q);
      3'd3:    rd_mux_s = 32'd0;
      3'd4:    rd_mux_s = zext(isr_q & ier_q);
      default: rd_resp_s = RESP_SLVERR;
    endcase
  end

  // Read channel FSM
  always_comb begin
    rstate_d  = rstate_q;
    arready_d = 1'b0;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (rd_hs_s) begin
          rstate_d = R_DATA;
          rvalid_d = 1'b1;
          rdata_d  = rd_mux_s;
          rresp_d  = rd_resp_s;
        end else begin
          arready_d = S_AXI_ARVALID;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
          rdata_d  = 32'd0;
          rresp_d  = RESP_OKAY;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        rstate_d = R_IDLE;
        rvalid_d = 1'b0;
        rdata_d  = 32'd0;
        rresp_d  = RESP_OKAY;
      end
    endcase
  end

  // State and register update
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
      gie_q     <= 1'b0;
      ier_q     <= '0;
      isr_q     <= '0;
      src_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      gie_q     <= gie_d;
      ier_q     <= ier_d;
      isr_q     <= isr_d;
      src_q     <= intr_src;
      irq_q     <= irq_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign irq           = C_IRQ_ACTIVE_STATE ? irq_q : ~irq_q;

endmodule

// File: tb/tb_axil_intr_responder.sv
// Directed plus randomized bench for axil_intr_responder, checked against a register-level model.
module tb_axil_intr_responder;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [0:0]  intr_src;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic gie_m, ier_m, isr_m;

  axil_intr_responder dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .intr_src(intr_src), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register-level model of the block's documented behaviour
  function automatic logic [1:0] model_write(input logic [2:0] idx, input logic [31:0] d,
                                             input logic [3:0] s);
    if (s[0]) begin
      if (idx == 3'd0) gie_m = d[0];
      if (idx == 3'd1) ier_m = d[0];
      if (idx == 3'd2 && d[0]) isr_m = 1'b1;
      if (idx == 3'd3 && d[0]) isr_m = 1'b0;
    end
    return (idx >= 3'd5) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return {2'b00, 31'd0, gie_m};
      3'd1:    return {2'b00, 31'd0, ier_m};
      3'd2:    return {2'b00, 31'd0, isr_m};
      3'd4:    return {2'b00, 31'd0, isr_m & ier_m};
      3'd3:    return 34'd0;
      default: return {2'b10, 32'd0};
    endcase
  endfunction

  function automatic logic irq_exp();
    return gie_m & ier_m & isr_m;
  endfunction

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit got;
    @(negedge ACLK);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (S_AXI_AWREADY && S_AXI_WREADY) begin got = 1'b1; break; end
      @(negedge ACLK);
    end
    check("aw_w_handshake", {31'd0, got}, 32'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (S_AXI_BVALID) begin got = 1'b1; break; end
      @(negedge ACLK);
    end
    check("bvalid_wait", {31'd0, got}, 32'd1);
    resp = S_AXI_BRESP;
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit got;
    @(negedge ACLK);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (S_AXI_ARREADY) begin got = 1'b1; break; end
      @(negedge ACLK);
    end
    check("ar_handshake", {31'd0, got}, 32'd1);
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (S_AXI_RVALID) begin got = 1'b1; break; end
      @(negedge ACLK);
    end
    check("rvalid_wait", {31'd0, got}, 32'd1);
    d = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic wr_chk(input string tag, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s);
    logic [1:0] resp, eresp;
    eresp = model_write(a[4:2], d, s);
    axi_write(a, d, s, resp);
    check({tag, "_bresp"}, {30'd0, resp}, {30'd0, eresp});
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a);
    logic [31:0] d;
    logic [1:0]  resp;
    logic [33:0] e;
    e = model_read(a[4:2]);
    axi_read(a, d, resp);
    check({tag, "_rdata"}, d, e[31:0]);
    check({tag, "_rresp"}, {30'd0, resp}, {30'd0, e[33:32]});
  endtask

  // One-cycle high pulse; irq (if enabled) must be active two cycles after the pulse starts
  task automatic pulse_src();
    @(negedge ACLK);
    intr_src = 1'b1;
    @(negedge ACLK);
    intr_src = 1'b0;
    isr_m = 1'b1;
    @(negedge ACLK);
  endtask

  initial begin
    logic [31:0] d0;
    logic [1:0]  r0;
    bit got;
    ARESET = 1'b1;
    S_AXI_AWADDR = 5'd0; S_AXI_ARADDR = 5'd0; S_AXI_AWPROT = 3'd0; S_AXI_ARPROT = 3'd0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'd0;
    S_AXI_ARVALID = 1'b0; S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1; intr_src = 1'b0;
    gie_m = 1'b0; ier_m = 1'b0; isr_m = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_ready", {29'd0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 32'd0);
    check("rst_valid", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    ARESET = 1'b0;

    rd_chk("rst_gie", 5'h00);
    rd_chk("rst_ier", 5'h04);
    rd_chk("rst_ipr", 5'h10);
    wr_chk("gie1", 5'h00, 32'h1, 4'hF);
    wr_chk("ier1", 5'h04, 32'h1, 4'hF);
    rd_chk("rb_gie", 5'h00);
    rd_chk("rb_ier", 5'h04);

    pulse_src();
    check("irq_after_pulse", {31'd0, irq}, 32'd1);
    rd_chk("ipr_set", 5'h10);
    wr_chk("iar", 5'h0C, 32'h1, 4'hF);
    check("irq_after_iar", {31'd0, irq}, 32'd0);
    rd_chk("ipr_clr", 5'h10);
    rd_chk("iar_reads0", 5'h0C);

    wr_chk("ier0", 5'h04, 32'h0, 4'hF);
    pulse_src();
    rd_chk("mask_isr", 5'h08);
    rd_chk("mask_ipr", 5'h10);
    check("mask_irq", {31'd0, irq}, 32'd0);
    wr_chk("ier_on", 5'h04, 32'h1, 4'hF);
    check("unmask_irq", {31'd0, irq}, 32'd1);
    wr_chk("iar2", 5'h0C, 32'h1, 4'hF);
    wr_chk("gie0", 5'h00, 32'h0, 4'hF);
    pulse_src();
    check("gie_mask_irq", {31'd0, irq}, 32'd0);
    rd_chk("gie_mask_isr", 5'h08);
    wr_chk("gie_on", 5'h00, 32'h1, 4'hF);
    check("gie_on_irq", {31'd0, irq}, 32'd1);

    // Rising edge lands on the same edge as the IAR write handshake
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h0C; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (S_AXI_AWREADY) begin got = 1'b1; break; end
      @(negedge ACLK);
    end
    check("coll_handshake", {31'd0, got}, 32'd1);
    intr_src = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; intr_src = 1'b0;
    repeat (3) @(negedge ACLK);
    check("coll_irq", {31'd0, irq}, 32'd1);
    rd_chk("coll_isr", 5'h08);
    wr_chk("iar_nostrb", 5'h0C, 32'hFFFF_FFFF, 4'h0);
    rd_chk("nostrb_isr", 5'h08);
    wr_chk("isr_sw_clr", 5'h0C, 32'h1, 4'h1);
    rd_chk("isr_cleared", 5'h08);
    wr_chk("isr_sw_set", 5'h08, 32'h1, 4'h1);
    rd_chk("isr_swset", 5'h08);
    wr_chk("iar3", 5'h0C, 32'h1, 4'h1);

    // AW without W must not be accepted
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
    got = 1'b0;
    repeat (5) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY || S_AXI_WREADY || S_AXI_BVALID) got = 1'b1;
    end
    check("aw_alone", {31'd0, got}, 32'd0);
    S_AXI_AWVALID = 1'b0;

    // Write response stall on an unmapped address
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    S_AXI_AWADDR = 5'h18; S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (S_AXI_AWREADY) break;
      @(negedge ACLK);
    end
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("bstall", {29'd0, S_AXI_BVALID, S_AXI_BRESP}, {29'd0, 1'b1, 2'b10});
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check("bstall_release", {31'd0, S_AXI_BVALID}, 32'd0);
    rd_chk("unm_gie", 5'h00);
    rd_chk("unm_ier", 5'h04);
    rd_chk("unm_isr", 5'h08);
    rd_chk("unm_rd", 5'h14);

    // Read data stall: an event during the stall must not disturb captured RDATA
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0; S_AXI_ARADDR = 5'h08; S_AXI_ARVALID = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (S_AXI_ARREADY) break;
      @(negedge ACLK);
    end
    @(posedge ACLK);
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    for (int k = 0; k < 4; k++) begin
      intr_src = (k == 1) ? 1'b1 : 1'b0;
      check("rstall", {S_AXI_RDATA[30:0], S_AXI_RVALID}, 32'd1);
      @(negedge ACLK);
    end
    isr_m = 1'b1;
    S_AXI_RREADY = 1'b1;
    @(negedge ACLK);
    check("rstall_release", {31'd0, S_AXI_RVALID}, 32'd0);
    rd_chk("rstall_isr", 5'h08);

    for (int it = 0; it < 60; it++) begin
      logic [2:0] idx;
      idx = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: rd_chk("rnd_rd", {idx, 2'b00});
        1: begin
          pulse_src();
          check("rnd_pulse_irq", {31'd0, irq}, {31'd0, irq_exp()});
        end
        default: begin
          wr_chk("rnd_wr", {idx, 2'b00}, $urandom, 4'($urandom_range(0, 15)));
          check("rnd_wr_irq", {31'd0, irq}, {31'd0, irq_exp()});
        end
      endcase
    end

    wr_chk("pre_gie", 5'h00, 32'h1, 4'hF);
    wr_chk("pre_ier", 5'h04, 32'h1, 4'hF);
    pulse_src();
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (S_AXI_BVALID) begin got = 1'b1; break; end
      @(negedge ACLK);
    end
    check("pre_rst_bvalid", {31'd0, got}, 32'd1);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    #2;
    ARESET = 1'b1;
    #1;
    check("async_valid", {29'd0, S_AXI_BVALID, S_AXI_RVALID, S_AXI_AWREADY}, 32'd0);
    check("async_irq", {29'd0, irq, S_AXI_BRESP}, 32'd0);
    repeat (2) @(negedge ACLK);
    S_AXI_BREADY = 1'b1;
    ARESET = 1'b0;
    gie_m = 1'b0; ier_m = 1'b0; isr_m = 1'b0;
    rd_chk("post_rst_gie", 5'h00);
    rd_chk("post_rst_isr", 5'h08);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_intr_responder.md
Name: axil_intr_responder

Overview:
AXI4-Lite slave that responds to the CPU/VIP master. It implements the interrupt register block: global enable, per-source enable, status, acknowledge and pending registers. It latches events from up to C_NUM_INTR peripheral sources and drives a single irq line. It sits behind the interconnect at the S_AXI_INTR base address, alongside the burst-memory slave of the same IP.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte-address width; register index is awaddr/araddr[4:2].
C_NUM_INTR, 1, number of interrupt sources (1..32).
C_INTR_SENSITIVITY, 1, detection mode: 1 = rising edge, 0 = level (high).
C_IRQ_ACTIVE_STATE, 1, irq polarity: 1 = active-high, 0 = active-low.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address accept
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data accept
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response accept
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address accept
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data accept
intr_src  in  C_NUM_INTR  peripheral event inputs, synchronous to ACLK
irq  out  1  interrupt request

Behaviour:
- Reset (ARESET=1, async): all READY/VALID outputs are 0; BRESP=RRESP=0; RDATA=0; all registers are 0; the edge-detect history is 0; irq is in the inactive state (~C_IRQ_ACTIVE_STATE).
- Register map (index = addr[4:2]):
  - 0x00 GIE: bit0 is R/W; other bits read 0.
  - 0x04 IER: bits [C_NUM_INTR-1:0] are R/W.
  - 0x08 ISR: status register. Reads return status. Writing 1 to a bit sets it (software trigger).
  - 0x0C IAR: write-1-to-clear on status; reads 0.
  - 0x10 IPR: read-only; value = ISR & IER.
  - Writes to IPR are ignored and return OKAY.
  - Indices 5..7 are unmapped: reads return 0 with SLVERR (2'b10); writes have no effect and return SLVERR.
- Write FSM, states W_IDLE -> W_RESP:
  - In W_IDLE, when AWVALID and WVALID are both high, assert AWREADY and WREADY together for exactly one cycle. Apply the write on that same edge, then go to W_RESP with BVALID=1.
  - AW or W arriving alone is not accepted until its partner arrives.
  - In W_RESP, hold BVALID/BRESP until BREADY, then return to W_IDLE.
  - Minimum write turnaround is 3 cycles.
- WSTRB: byte lanes with strobe 0 are not written in any register. An IAR write with WSTRB=0 clears nothing.
- Read FSM, states R_IDLE -> R_DATA:
  - In R_IDLE, on ARVALID, assert ARREADY for one cycle. Register RDATA/RRESP and go to R_DATA with RVALID=1 on the next cycle.
  - Hold RDATA/RRESP/RVALID until RREADY, then return to R_IDLE.
  - Read and write FSMs are independent and may be active at the same time.
- Event detection, per bit i:
  - Edge mode: evt[i] = intr_src[i] & ~src_q[i]; src_q is registered every cycle.
  - Level mode: evt[i] = intr_src[i].
  - ISR[i] is set on evt[i] regardless of IER/GIE.
- Same-cycle event and IAR clear on the same bit: set wins, ISR stays 1. A same-cycle ISR software write-1 is ORed with events.
- irq:
  - irq_int = GIE[0] & |(ISR & IER), registered, so irq reflects a change 1 cycle after the ISR/IER/GIE update.
  - irq = irq_int when C_IRQ_ACTIVE_STATE=1, ~irq_int otherwise.
- A read of ISR/IPR returns the value registered at the ARREADY edge.
- Reset mid-transaction drops any outstanding BVALID/RVALID immediately. The master must reissue.

Test Plan:
- Register R/W: after reset, read 0x00, 0x04, 0x10 -> all 0, RRESP=OKAY. Write GIE=1, IER=1, then read back -> 0x1, 0x1.
- Interrupt flow: GIE=1, IER=1, pulse intr_src[0] for 1 cycle -> irq active within 2 cycles, IPR reads 0x1. Write IAR=1 -> irq inactive 1 cycle after BVALID, IPR reads 0x0.
- Masking: IER=0, pulse intr_src[0] -> ISR=0x1, IPR=0x0, irq inactive. Then write IER=1 -> irq active one cycle later. Same check with GIE=0 and IER=1.
- Collision: in edge mode, apply a rising edge on intr_src[0] in the same cycle as an IAR=1 write -> ISR[0] remains 1 and irq remains active.
- Handshake/errors: AWVALID without WVALID for 5 cycles -> AWREADY stays 0. Hold BREADY/RREADY low for 4 cycles -> BVALID/RVALID and data stay stable. Read 0x14 -> RDATA=0, RRESP=2'b10. Write 0x18 -> BRESP=2'b10 and no register changes.
- Async reset: assert ARESET while BVALID=1 and irq active -> all outputs reach their reset values without waiting for a clock edge. After release, GIE reads 0.
